// File: rtl/pc_trap_sequencer.sv
// Next-PC sequencer for the single-cycle MIPS core: owns PC, user/kernel state,
// EPC and cause, and arbitrates undefined-instruction/ERET exceptions and edge-latched IRQs.
module pc_trap_sequencer #(
  parameter int          IRQ_CH     = 4,
  parameter logic [31:0] RESET_VEC  = 32'h8000_0000,
  parameter logic [31:0] ILLOP_VEC  = 32'h8000_0004,
  parameter logic [31:0] XADR_VEC   = 32'h8000_0008,
  parameter logic [31:0] USER_ENTRY = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic [1:0]        pc_src,
  input  logic              branch,
  input  logic [31:0]       conba,
  input  logic [25:0]       jt,
  input  logic [31:0]       data_a,
  input  logic              undef_ins,
  input  logic              eret,
  input  logic [IRQ_CH-1:0] irq,
  input  logic [IRQ_CH-1:0] irq_mask,
  output logic [31:0]       pc,
  output logic [31:0]       epc,
  output logic [7:0]        cause,
  output logic              kernel,
  output logic              flush,
  output logic [IRQ_CH-1:0] irq_pend
);

  typedef enum logic {KERN, USER} state_t;

  state_t            state_reg, state_next;
  logic [31:0]       pc_reg, pc_next;
  logic [31:0]       epc_reg, epc_next;
  logic [7:0]        cause_reg, cause_next;
  logic [IRQ_CH-1:0] irq_prev_reg;
  logic [IRQ_CH-1:0] irq_pend_reg, irq_pend_next;
  logic [IRQ_CH-1:0] irq_rise, irq_active, irq_clr;
  logic [31:0]       pc_plus4, seq_pc;
  logic [7:0]        irq_idx;
  logic              irq_hit;
  logic              take_irq;

  assign pc_plus4   = pc_reg + 32'd4;
  assign irq_active = irq_pend_reg & irq_mask;

  // Lowest-index enabled pending channel wins.
  always_comb begin
    irq_hit = 1'b0;
    irq_idx = '0;
    for (int i = IRQ_CH - 1; i >= 0; i--) begin
      if (irq_active[i]) begin
        irq_hit = 1'b1;
        irq_idx = 8'(i);
      end
    end
  end

  generate
    for (genvar gi = 0; gi < IRQ_CH; gi++) begin : g_irq
      assign irq_rise[gi] = irq[gi] & ~irq_prev_reg[gi];
      assign irq_clr[gi]  = take_irq && (irq_idx == 8'(gi));
    end
  endgenerate

  // Set wins over clear so an edge arriving on the service cycle is not lost.
  assign irq_pend_next = (irq_pend_reg & ~irq_clr) | irq_rise;

  always_comb begin
    seq_pc = pc_plus4;
    case (pc_src)
      2'd0: seq_pc = pc_plus4;
      2'd1: seq_pc = branch ? conba : pc_plus4;
      2'd2: seq_pc = {pc_plus4[31:28], jt, 2'b00};
      2'd3: begin
        seq_pc = data_a;
        if (state_reg == USER) seq_pc[31] = 1'b0;
      end
      default: seq_pc = pc_plus4;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    epc_next   = epc_reg;
    cause_next = cause_reg;
    flush      = 1'b0;
    take_irq   = 1'b0;
    if (!stall) begin
      case (state_reg)
        USER: begin
          if (undef_ins || eret) begin
            flush      = 1'b1;
            pc_next    = XADR_VEC;
            epc_next   = pc_plus4;
            cause_next = 8'd0;
            state_next = KERN;
          end else if (irq_hit) begin
            // Interrupted instruction is squashed and re-executed after ERET.
            flush      = 1'b1;
            take_irq   = 1'b1;
            pc_next    = ILLOP_VEC;
            epc_next   = pc_reg;
            cause_next = irq_idx + 8'd1;
            state_next = KERN;
          end else begin
            pc_next = seq_pc;
          end
        end
        KERN: begin
          if (eret) begin
            pc_next    = epc_reg;
            state_next = USER;
          end else if (undef_ins) begin
            pc_next = pc_plus4;
          end else begin
            pc_next = seq_pc;
          end
        end
        default: state_next = KERN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= KERN;
      pc_reg       <= RESET_VEC;
      epc_reg      <= USER_ENTRY;
      cause_reg    <= 8'd0;
      irq_prev_reg <= '0;
      irq_pend_reg <= '0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      epc_reg      <= epc_next;
      cause_reg    <= cause_next;
      irq_prev_reg <= irq;
      irq_pend_reg <= irq_pend_next;
    end
  end

  assign pc       = pc_reg;
  assign epc      = epc_reg;
  assign cause    = cause_reg;
  assign kernel   = (state_reg == KERN);
  assign irq_pend = irq_pend_reg;

endmodule

// File: tb/tb_pc_trap_sequencer.sv
// Self-checking bench for pc_trap_sequencer: expected pc/kernel pushed per cycle, popped after the edge.
module tb_pc_trap_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall;
  logic [1:0]  pc_src;
  logic        branch;
  logic [31:0] conba;
  logic [25:0] jt;
  logic [31:0] data_a;
  logic        undef_ins;
  logic        eret;
  logic [3:0]  irq;
  logic [3:0]  irq_mask;
  logic [31:0] pc;
  logic [31:0] epc;
  logic [7:0]  cause;
  logic        kernel;
  logic        flush;
  logic [3:0]  irq_pend;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        kernel;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   tests_run = 0;
  int   fails = 0;

  pc_trap_sequencer #(.IRQ_CH(4)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .pc_src(pc_src), .branch(branch),
    .conba(conba), .jt(jt), .data_a(data_a), .undef_ins(undef_ins), .eret(eret),
    .irq(irq), .irq_mask(irq_mask), .pc(pc), .epc(epc), .cause(cause),
    .kernel(kernel), .flush(flush), .irq_pend(irq_pend)
  );

  always #5 clk = ~clk;

  task automatic idle();
    stall = 0; pc_src = 0; branch = 0; conba = 0; jt = 0; data_a = 0;
    undef_ins = 0; eret = 0; irq = 0; irq_mask = 4'hF;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Assert reset mid-cycle, release 1 ns after the next rising edge.
  task automatic do_reset();
    idle();
    @(posedge clk);
    #3 rst_n = 0;
    #1;
    @(posedge clk);
    #1 rst_n = 1;
  endtask

  // From reset: ERET to USER_ENTRY, then jr to addr in USER.
  task automatic go_user(input logic [31:0] addr);
    eret = 1; cyc(); eret = 0;
    pc_src = 3; data_a = addr; cyc();
    pc_src = 0; data_a = 0;
  endtask

  task automatic test_reset();
    idle();
    pc_src = 3; data_a = 32'h1234_5678; cyc(); cyc();
    pc_src = 0;
    @(posedge clk);
    #3 rst_n = 0;
    #1;
    tests_run++;
    if (pc !== 32'h8000_0000 || epc !== 32'h0 || kernel !== 1'b1 || cause !== 8'd0 || irq_pend !== 4'h0) begin
      fails++;
      $display("FAIL reset_async: pc=%h epc=%h kernel=%b cause=%0d pend=%b required pc=80000000 epc=0 kernel=1 cause=0 pend=0000",
               pc, epc, kernel, cause, irq_pend);
    end
    @(posedge clk);
    #1 rst_n = 1;
    #1;
    tests_run++;
    if (flush !== 1'b0) begin
      fails++; $display("FAIL reset_flush: flush=%b required 0", flush);
    end
    eret = 1;
    exp_q.push_back('{"reset_eret", 32'h0, 1'b0});
    cyc(); eret = 0;
    e = exp_q.pop_front(); tests_run++;
    if (pc !== e.pc || kernel !== e.kernel) begin
      fails++; $display("FAIL %s: pc=%h kernel=%b required pc=%h kernel=%b", e.name, pc, kernel, e.pc, e.kernel);
    end
    $display("[TB] reset: pc=%h kernel=%b", pc, kernel);
  endtask

  task automatic test_irq_priority();
    do_reset();
    eret = 1; cyc(); eret = 0;
    pc_src = 3; data_a = 32'h100; irq = 4'b0101;
    exp_q.push_back('{"irq_setup", 32'h100, 1'b0});
    cyc(); pc_src = 0; data_a = 0;
    e = exp_q.pop_front(); tests_run++;
    if (pc !== e.pc || kernel !== e.kernel || irq_pend !== 4'b0101) begin
      fails++; $display("FAIL %s: pc=%h kernel=%b pend=%b required pc=%h kernel=%b pend=0101", e.name, pc, kernel, irq_pend, e.pc, e.kernel);
    end
    #1; tests_run++;
    if (flush !== 1'b1) begin
      fails++; $display("FAIL irq_flush: flush=%b required 1", flush);
    end
    exp_q.push_back('{"irq_entry", 32'h8000_0004, 1'b1});
    cyc();
    e = exp_q.pop_front(); tests_run++;
    if (pc !== e.pc || kernel !== e.kernel || epc !== 32'h100 || cause !== 8'd1 || irq_pend !== 4'b0100) begin
      fails++; $display("FAIL %s: pc=%h kernel=%b epc=%h cause=%0d pend=%b required pc=%h kernel=%b epc=100 cause=1 pend=0100",
                        e.name, pc, kernel, epc, cause, irq_pend, e.pc, e.kernel);
    end
    $display("[TB] irq_priority: pc=%h epc=%h cause=%0d pend=%b", pc, epc, cause, irq_pend);
    // Return with channel 2 masked: it must stay pending without trapping.
    eret = 1; irq_mask = 4'h0;
    exp_q.push_back('{"irq_eret_masked", 32'h100, 1'b0});
    cyc(); eret = 0;
    e = exp_q.pop_front(); tests_run++;
    if (pc !== e.pc || kernel !== e.kernel) begin
      fails++; $display("FAIL %s: pc=%h kernel=%b required pc=%h kernel=%b", e.name, pc, kernel, e.pc, e.kernel);
    end
    #1; tests_run++;
    if (flush !== 1'b0) begin
      fails++; $display("FAIL masked_flush: flush=%b required 0", flush);
    end
    exp_q.push_back('{"masked_run", 32'h104, 1'b0});
    cyc();
    e = exp_q.pop_front(); tests_run++;
    if (pc !== e.pc || kernel !== e.kernel || irq_pend !== 4'b0100) begin
      fails++; $display("FAIL %s: pc=%h kernel=%b pend=%b required pc=%h kernel=%b pend=0100", e.name, pc, kernel, irq_pend, e.pc, e.kernel);
    end
    irq_mask = 4'h4;
    #1; tests_run++;
    if (flush !== 1'b1) begin
      fails++; $display("FAIL unmask_flush: flush=%b required 1", flush);
    end
    exp_q.push_back('{"unmask_entry", 32'h8000_0004, 1'b1});
    cyc();
    e = exp_q.pop_front(); tests_run++;
    if (pc !== e.pc || kernel !== e.kernel || epc !== 32'h104 || cause !== 8'd3 || irq_pend !== 4'b0000) begin
      fails++; $display("FAIL %s: pc=%h kernel=%b epc=%h cause=%0d pend=%b required pc=%h kernel=%b epc=104 cause=3 pend=0000",
                        e.name, pc, kernel, epc, cause, irq_pend, e.pc, e.kernel);
    end
    $display("[TB] irq_unmask: pc=%h epc=%h cause=%0d", pc, epc, cause);
    irq = 0; irq_mask = 4'hF;
  endtask

  task automatic test_undef();
    do_reset();
    go_user(32'h40);
    undef_ins = 1;
    #1; tests_run++;
    if (flush !== 1'b1) begin
      fails++; $display("FAIL undef_flush: flush=%b required 1", flush);
    end
    exp_q.push_back('{"undef_entry", 32'h8000_0008, 1'b1});
    cyc(); undef_ins = 0;
    e = exp_q.pop_front(); tests_run++;
    if (pc !== e.pc || kernel !== e.kernel || epc !== 32'h44 || cause !== 8'd0) begin
      fails++; $display("FAIL %s: pc=%h kernel=%b epc=%h cause=%0d required pc=%h kernel=%b epc=44 cause=0",
                        e.name, pc, kernel, epc, cause, e.pc, e.kernel);
    end
    eret = 1;
    exp_q.push_back('{"undef_eret", 32'h44, 1'b0});
    cyc();
    e = exp_q.pop_front(); tests_run++;
    if (pc !== e.pc || kernel !== e.kernel) begin
      fails++; $display("FAIL %s: pc=%h kernel=%b required pc=%h kernel=%b", e.name, pc, kernel, e.pc, e.kernel);
    end
    // ERET held high now in USER is itself an exception.
    exp_q.push_back('{"user_eret_trap", 32'h8000_0008, 1'b1});
    cyc(); eret = 0;
    e = exp_q.pop_front(); tests_run++;
    if (pc !== e.pc || kernel !== e.kernel || epc !== 32'h48 || cause !== 8'd0) begin
      fails++; $display("FAIL %s: pc=%h kernel=%b epc=%h cause=%0d required pc=%h kernel=%b epc=48 cause=0",
                        e.name, pc, kernel, epc, cause, e.pc, e.kernel);
    end
    $display("[TB] undef: pc=%h epc=%h cause=%0d", pc, epc, cause);
  endtask

  task automatic test_kernel_irq();
    do_reset();
    go_user(32'h1FC);
    undef_ins = 1; cyc(); undef_ins = 0;
    irq = 4'b0010;
    #1; tests_run++;
    if (flush !== 1'b0) begin
      fails++; $display("FAIL kern_irq_flush: flush=%b required 0", flush);
    end
    exp_q.push_back('{"kern_irq_pend", 32'h8000_000C, 1'b1});
    cyc();
    e = exp_q.pop_front(); tests_run++;
    if (pc !== e.pc || kernel !== e.kernel || irq_pend !== 4'b0010 || epc !== 32'h200) begin
      fails++; $display("FAIL %s: pc=%h kernel=%b pend=%b epc=%h required pc=%h kernel=%b pend=0010 epc=200",
                        e.name, pc, kernel, irq_pend, epc, e.pc, e.kernel);
    end
    undef_ins = 1; pc_src = 2; jt = 26'h3FF_FFFF;
    exp_q.push_back('{"kern_undef_ignored", 32'h8000_0010, 1'b1});
    cyc(); undef_ins = 0; pc_src = 0; jt = 0;
    e = exp_q.pop_front(); tests_run++;
    if (pc !== e.pc || kernel !== e.kernel) begin
      fails++; $display("FAIL %s: pc=%h kernel=%b required pc=%h kernel=%b", e.name, pc, kernel, e.pc, e.kernel);
    end
    eret = 1;
    exp_q.push_back('{"kern_eret", 32'h200, 1'b0});
    cyc(); eret = 0;
    e = exp_q.pop_front(); tests_run++;
    if (pc !== e.pc || kernel !== e.kernel) begin
      fails++; $display("FAIL %s: pc=%h kernel=%b required pc=%h kernel=%b", e.name, pc, kernel, e.pc, e.kernel);
    end
    #1; tests_run++;
    if (flush !== 1'b1) begin
      fails++; $display("FAIL deferred_irq_flush: flush=%b required 1", flush);
    end
    exp_q.push_back('{"deferred_irq", 32'h8000_0004, 1'b1});
    cyc();
    e = exp_q.pop_front(); tests_run++;
    if (pc !== e.pc || kernel !== e.kernel || epc !== 32'h200 || cause !== 8'd2 || irq_pend !== 4'b0000) begin
      fails++; $display("FAIL %s: pc=%h kernel=%b epc=%h cause=%0d pend=%b required pc=%h kernel=%b epc=200 cause=2 pend=0000",
                        e.name, pc, kernel, epc, cause, irq_pend, e.pc, e.kernel);
    end
    $display("[TB] kernel_irq: pc=%h epc=%h cause=%0d", pc, epc, cause);
    irq = 0;
  endtask

  task automatic test_jumps();
    logic [31:0] tgt [6];
    logic [31:0] want [6];
    logic [1:0]  src [6];
    logic        brn [6];
    do_reset();
    // Kernel jr keeps bit 31; sequential wrap from FFFF_FFFC.
    pc_src = 3; data_a = 32'hFFFF_FFFC;
    exp_q.push_back('{"kern_jr", 32'hFFFF_FFFC, 1'b1});
    cyc(); pc_src = 0;
    e = exp_q.pop_front(); tests_run++;
    if (pc !== e.pc || kernel !== e.kernel) begin
      fails++; $display("FAIL %s: pc=%h kernel=%b required pc=%h kernel=%b", e.name, pc, kernel, e.pc, e.kernel);
    end
    exp_q.push_back('{"pc_wrap", 32'h0, 1'b1});
    cyc();
    e = exp_q.pop_front(); tests_run++;
    if (pc !== e.pc || kernel !== e.kernel) begin
      fails++; $display("FAIL %s: pc=%h kernel=%b required pc=%h kernel=%b", e.name, pc, kernel, e.pc, e.kernel);
    end
    eret = 1; cyc(); eret = 0;
    src  = '{2'd3, 2'd3, 2'd2, 2'd1, 2'd1, 2'd0};
    brn  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tgt  = '{32'h8000_1234, 32'h1000_0000, 32'h0, 32'h0, 32'h2000_0000, 32'h0};
    want = '{32'h0000_1234, 32'h1000_0000, 32'h1000_0004, 32'h1000_0008, 32'h2000_0000, 32'h2000_0004};
    for (int i = 0; i < 6; i++) begin
      pc_src = src[i]; branch = brn[i]; data_a = tgt[i]; conba = tgt[i]; jt = 26'h1;
      exp_q.push_back('{$sformatf("user_jump%0d", i), want[i], 1'b0});
      cyc();
      e = exp_q.pop_front(); tests_run++;
      if (pc !== e.pc || kernel !== e.kernel) begin
        fails++; $display("FAIL %s: pc=%h kernel=%b required pc=%h kernel=%b", e.name, pc, kernel, e.pc, e.kernel);
      end
      $display("[TB] jump %0d: src=%0d pc=%h", i, src[i], pc);
    end
    idle();
  endtask

  task automatic test_stall();
    do_reset();
    go_user(32'h300);
    stall = 1; undef_ins = 1; irq = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      #1; tests_run++;
      if (flush !== 1'b0) begin
        fails++; $display("FAIL stall_flush%0d: flush=%b required 0", i, flush);
      end
      exp_q.push_back('{$sformatf("stall_hold%0d", i), 32'h300, 1'b0});
      cyc();
      e = exp_q.pop_front(); tests_run++;
      if (pc !== e.pc || kernel !== e.kernel || irq_pend !== 4'b1000) begin
        fails++; $display("FAIL %s: pc=%h kernel=%b pend=%b required pc=%h kernel=%b pend=1000", e.name, pc, kernel, irq_pend, e.pc, e.kernel);
      end
    end
    stall = 0;
    #1; tests_run++;
    if (flush !== 1'b1) begin
      fails++; $display("FAIL stall_release_flush: flush=%b required 1", flush);
    end
    exp_q.push_back('{"stall_release", 32'h8000_0008, 1'b1});
    cyc(); undef_ins = 0;
    e = exp_q.pop_front(); tests_run++;
    if (pc !== e.pc || kernel !== e.kernel || epc !== 32'h304 || cause !== 8'd0 || irq_pend !== 4'b1000) begin
      fails++; $display("FAIL %s: pc=%h kernel=%b epc=%h cause=%0d pend=%b required pc=%h kernel=%b epc=304 cause=0 pend=1000",
                        e.name, pc, kernel, epc, cause, irq_pend, e.pc, e.kernel);
    end
    $display("[TB] stall: pc=%h epc=%h cause=%0d", pc, epc, cause);
    stall = 1; eret = 1;
    exp_q.push_back('{"kern_stall_eret", 32'h8000_0008, 1'b1});
    cyc();
    e = exp_q.pop_front(); tests_run++;
    if (pc !== e.pc || kernel !== e.kernel) begin
      fails++; $display("FAIL %s: pc=%h kernel=%b required pc=%h kernel=%b", e.name, pc, kernel, e.pc, e.kernel);
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_irq_priority();
    test_undef();
    test_kernel_irq();
    test_jumps();
    test_stall();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
